// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  // Arbiter FSM: IDLE spends one cycle choosing an owner, BURST moves data.
  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Modulo-n increment used to advance the round-robin pointer.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return ((ptr + 1) >= n) ? 0 : (ptr + 1);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: returns the first set bit of valid,
// searching ptr, ptr+1, ... modulo NUM_REQ.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDW-1:0]     ptr,
  output logic               found,
  output logic [IDW-1:0]     idx
);

  logic [IDW:0] cand;

  // Walk candidates from farthest to nearest so the nearest valid one wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NUM_REQ)) begin
        cand = cand - (IDW+1)'(NUM_REQ);
      end
      if (valid[cand[IDW-1:0]]) begin
        found = 1'b1;
        idx   = cand[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ producers.
// Each grant lasts at most MAX_BURST accepted beats and ends early when the
// owner drops valid. A grant is always preceded by a one-cycle IDLE bubble.
//
// Handshake: a producer beat transfers in a cycle where req_valid[i] and
// req_ready[i] are both high at the rising edge; the producer must keep
// data stable while valid is high and ready is low. req_ready is at most
// one-hot and only ever set for the current owner while the FIFO is not full.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int WIDTH     = 8,
  parameter  int MAX_BURST = 4,
  localparam int IDW       = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     fifo_full,
  output logic                     fifo_wr_en,
  output logic [WIDTH-1:0]         fifo_data_in,
  output logic [IDW-1:0]           fifo_src,
  output logic                     busy,
  output logic [IDW-1:0]           grant_id
);

  // beat_cnt holds 0..MAX_BURST-1; the final beat ends the burst instead of
  // being stored.
  localparam int BCW = $clog2(MAX_BURST + 1);

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   owner;
  logic [BCW-1:0]   beat_cnt;

  logic             pick_found;
  logic [IDW-1:0]   pick_idx;
  logic             owner_valid;
  logic             xfer;
  logic             last_beat;
  logic [WIDTH-1:0] data_arr [NUM_REQ];

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_picker (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Unpack the flat producer data bus into per-producer words.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      data_arr[i] = req_data[i*WIDTH +: WIDTH];
    end
  end

  assign owner_valid = req_valid[owner];
  assign xfer        = (state == BURST) && owner_valid && !fifo_full;
  assign last_beat   = (beat_cnt == BCW'(MAX_BURST - 1));

  // Arbitration FSM with registered busy/grant_id status.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      beat_cnt <= '0;
      busy     <= 1'b0;
      grant_id <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en && pick_found) begin
            state    <= BURST;
            owner    <= pick_idx;
            beat_cnt <= '0;
            busy     <= 1'b1;
            grant_id <= pick_idx;
          end
        end
        BURST: begin
          if (!owner_valid || (xfer && last_beat)) begin
            state    <= IDLE;
            rr_ptr   <= IDW'(rr_next(32'(owner), NUM_REQ));
            beat_cnt <= '0;
            busy     <= 1'b0;
            grant_id <= '0;
          end else if (xfer) begin
            beat_cnt <= beat_cnt + BCW'(1);
          end
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          grant_id <= '0;
        end
      endcase
    end
  end

  // Only the owner sees ready, and only while the FIFO can take a word.
  always_comb begin
    req_ready = '0;
    if (state == BURST) begin
      req_ready[owner] = !fifo_full;
    end
  end

  // Zero-latency write path; data and source are zeroed when not writing.
  always_comb begin
    fifo_wr_en   = xfer;
    fifo_data_in = '0;
    fifo_src     = '0;
    if (xfer) begin
      fifo_data_in = data_arr[owner];
      fifo_src     = owner;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NUM_REQ=4, WIDTH=8, MAX_BURST=4).
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int WIDTH     = 8;
  localparam int MAX_BURST = 4;
  localparam int IDW       = 2;
  localparam logic [17:0] IDLE_OBS = 18'h0;

  logic                     clk;
  logic                     rst;
  logic                     en;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     fifo_full;
  logic                     fifo_wr_en;
  logic [WIDTH-1:0]         fifo_data_in;
  logic [IDW-1:0]           fifo_src;
  logic                     busy;
  logic [IDW-1:0]           grant_id;
  logic [17:0]              obs;

  int          n_total;
  int          n_bad;
  int          rem  [NUM_REQ];
  logic [7:0]  dval [NUM_REQ];

  fifo_wr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .WIDTH     (WIDTH),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_data_in (fifo_data_in),
    .fifo_src     (fifo_src),
    .busy         (busy),
    .grant_id     (grant_id)
  );

  assign obs = {req_ready, busy, grant_id, fifo_wr_en, fifo_src, fifo_data_in};

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Expected observation word: {ready, busy, grant_id, wr_en, src, data}.
  function automatic logic [17:0] mk(input logic b, input int g, input logic w,
                                     input logic [7:0] d, input logic full);
    logic [3:0] rdy;
    logic [1:0] gi;
    gi  = 2'(g);
    rdy = (b && !full) ? (4'b0001 << gi) : 4'b0000;
    return {rdy, b, (b ? gi : 2'b00), w, (w ? gi : 2'b00), (w ? d : 8'h00)};
  endfunction

  task automatic chk(input string tag, input logic [17:0] got, input logic [17:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // driver: producer i is valid while rem[i] != 0 (negative = endless).
  task automatic apply();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i]             = (rem[i] != 0);
      req_data[i*WIDTH +: WIDTH] = dval[i];
    end
  endtask

  // One clock: check at negedge, then advance producers that handshook.
  task automatic run_cycle(input logic [17:0] exp, input string tag);
    logic [NUM_REQ-1:0] hs;
    @(negedge clk);
    chk(tag, obs, exp);
    hs = req_ready & req_valid;
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (hs[i]) begin
        dval[i] = dval[i] + 8'd1;
        if (rem[i] > 0) rem[i] = rem[i] - 1;
      end
    end
    apply();
  endtask

  task automatic clear_producers();
    for (int i = 0; i < NUM_REQ; i++) begin
      rem[i]  = 0;
      dval[i] = 8'h00;
    end
    apply();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    n_total   = 0;
    n_bad     = 0;
    rst       = 1'b0;
    en        = 1'b1;
    fifo_full = 1'b0;
    req_valid = '0;
    req_data  = '0;
    clear_producers();

    // 1: held in reset with random inputs, then idle with nothing valid
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      req_valid = 4'($urandom_range(0, 15));
      req_data  = 32'($urandom);
      fifo_full = 1'($urandom_range(0, 1));
      en        = 1'($urandom_range(0, 1));
      #2;
      chk($sformatf("t1_rst%0d", c), obs, IDLE_OBS);
    end
    fifo_full = 1'b0;
    en        = 1'b1;
    clear_producers();
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int c = 0; c < 10; c++) run_cycle(IDLE_OBS, $sformatf("t1_idle%0d", c));

    // 2: single producer 2, six beats, split 4 + 2
    rem[2] = 6; dval[2] = 8'h10; apply();
    run_cycle(IDLE_OBS, "t2_bub0");
    for (int b = 0; b < 4; b++) run_cycle(mk(1, 2, 1, 8'(8'h10 + b), 0), $sformatf("t2_a%0d", b));
    run_cycle(IDLE_OBS, "t2_bub1");
    for (int b = 0; b < 2; b++) run_cycle(mk(1, 2, 1, 8'(8'h14 + b), 0), $sformatf("t2_b%0d", b));
    run_cycle(mk(1, 2, 0, 8'h00, 0), "t2_drop");
    run_cycle(IDLE_OBS, "t2_idle");

    // 3: all producers always valid, order 0,1,2,3,0 with 5-cycle period
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      rem[i]  = -1;
      dval[i] = 8'(8'h40 + 16 * i);
    end
    apply();
    for (int g = 0; g < 5; g++) begin
      run_cycle(IDLE_OBS, $sformatf("t3_bub%0d", g));
      for (int b = 0; b < MAX_BURST; b++) begin
        run_cycle(mk(1, g % 4, 1, 8'(8'h40 + 16 * (g % 4) + 4 * (g / 4) + b), 0),
                  $sformatf("t3_g%0d_b%0d", g, b));
      end
    end
    clear_producers();
    run_cycle(IDLE_OBS, "t3_end");

    // 4: full stall mid-burst on producer 1, en low during the burst,
    //    then rotation to 2, then en low blocks a new grant
    rem[1] = 8; dval[1] = 8'h80;
    rem[2] = 1; dval[2] = 8'h90;
    apply();
    run_cycle(IDLE_OBS, "t4_bub0");
    run_cycle(mk(1, 1, 1, 8'h80, 0), "t4_b0");
    run_cycle(mk(1, 1, 1, 8'h81, 0), "t4_b1");
    en = 1'b0;
    fifo_full = 1'b1;
    for (int c = 0; c < 3; c++) run_cycle(mk(1, 1, 0, 8'h00, 1), $sformatf("t4_full%0d", c));
    fifo_full = 1'b0;
    run_cycle(mk(1, 1, 1, 8'h82, 0), "t4_b2");
    run_cycle(mk(1, 1, 1, 8'h83, 0), "t4_b3");
    en = 1'b1;
    run_cycle(IDLE_OBS, "t4_bub1");
    run_cycle(mk(1, 2, 1, 8'h90, 0), "t4_p2");
    run_cycle(mk(1, 2, 0, 8'h00, 0), "t4_p2drop");
    en = 1'b0;
    run_cycle(IDLE_OBS, "t4_en0_a");
    run_cycle(IDLE_OBS, "t4_en0_b");
    en = 1'b1;
    clear_producers();
    run_cycle(IDLE_OBS, "t4_end");

    // 5: producers 0 and 3; 0 drops after one beat
    do_reset();
    rem[0] = 1; dval[0] = 8'hA0;
    rem[3] = 2; dval[3] = 8'hB0;
    apply();
    run_cycle(IDLE_OBS, "t5_bub0");
    run_cycle(mk(1, 0, 1, 8'hA0, 0), "t5_p0");
    run_cycle(mk(1, 0, 0, 8'h00, 0), "t5_p0drop");
    run_cycle(IDLE_OBS, "t5_bub1");
    run_cycle(mk(1, 3, 1, 8'hB0, 0), "t5_p3a");
    run_cycle(mk(1, 3, 1, 8'hB1, 0), "t5_p3b");
    rem[0] = 1; apply();
    run_cycle(mk(1, 3, 0, 8'h00, 0), "t5_p3drop");
    run_cycle(IDLE_OBS, "t5_bub2");
    run_cycle(mk(1, 0, 1, 8'hA1, 0), "t5_p0again");
    run_cycle(mk(1, 0, 0, 8'h00, 0), "t5_p0drop2");
    run_cycle(IDLE_OBS, "t5_end");

    // 6: reset after beat 2 of producer 2, restart from index 0
    clear_producers();
    rem[2] = 8; dval[2] = 8'hC0; apply();
    run_cycle(IDLE_OBS, "t6_bub0");
    run_cycle(mk(1, 2, 1, 8'hC0, 0), "t6_b0");
    run_cycle(mk(1, 2, 1, 8'hC1, 0), "t6_b1");
    rst = 1'b0;
    #1;
    chk("t6_rst_now", obs, IDLE_OBS);
    @(posedge clk);
    #1;
    chk("t6_rst_hold", obs, IDLE_OBS);
    clear_producers();
    rem[1] = 1; dval[1] = 8'hD0;
    rem[3] = 1; dval[3] = 8'hE0;
    apply();
    rst = 1'b1;
    run_cycle(IDLE_OBS, "t6_bub1");
    run_cycle(mk(1, 1, 1, 8'hD0, 0), "t6_p1");
    run_cycle(mk(1, 1, 0, 8'h00, 0), "t6_p1drop");
    run_cycle(IDLE_OBS, "t6_bub2");
    run_cycle(mk(1, 3, 1, 8'hE0, 0), "t6_p3");
    run_cycle(mk(1, 3, 0, 8'h00, 0), "t6_p3drop");
    run_cycle(IDLE_OBS, "t6_end");

    // final report
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Shares the write port of one async_fifo between NUM_REQ producers using round-robin arbitration with bounded bursts. Each producer has a valid/ready handshake. The arbiter drives the FIFO's wr_en/data_in, honours the FIFO's full flag, and tags each written word with its source ID. It sits directly in front of the FIFO write side, in the FIFO's clk domain.

Parameters:
NUM_REQ, 4, number of producers (2..16).
WIDTH, 8, data width per producer; matches the FIFO WIDTH.
MAX_BURST, 4, maximum accepted beats per grant (1..255).
IDW, $clog2(NUM_REQ), localparam: source-ID width.

Ports:
clk  in  1  clock; all logic is rising-edge.
rst  in  1  asynchronous, active-low reset (0 = in reset).
en  in  1  arbitration enable; gates new grants only.
req_valid  in  NUM_REQ  per-producer data valid.
req_data  in  NUM_REQ*WIDTH  packed producer data; producer i uses slice [i*WIDTH +: WIDTH].
req_ready  out  NUM_REQ  per-producer accept, one-hot or zero.
fifo_full  in  1  FIFO full flag.
fifo_wr_en  out  1  FIFO write strobe.
fifo_data_in  out  WIDTH  FIFO write data.
fifo_src  out  IDW  source ID of the current write.
busy  out  1  high while in BURST.
grant_id  out  IDW  current owner; 0 when idle.

Behaviour:
- Reset (rst=0) takes effect immediately, asynchronously:
  - state = IDLE, rr_ptr = 0, owner = 0, beat_cnt = 0.
  - req_ready, fifo_wr_en, fifo_src, busy and grant_id are all 0.
  - fifo_data_in = 0.
- States: IDLE, BURST.
- IDLE:
  - req_ready = 0 and fifo_wr_en = 0.
  - If en=1 and any req_valid is high, pick the first valid index searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Register that index as owner, clear beat_cnt and move to BURST on the next edge.
  - This is a fixed 1-cycle arbitration bubble.
- BURST:
  - req_ready[owner] = !fifo_full; all other ready bits are 0.
  - A transfer occurs when req_valid[owner] & !fifo_full.
  - On a transfer: fifo_wr_en = 1, fifo_data_in = req_data[owner], fifo_src = owner.
  - All of these are combinational in the same cycle; latency from producer to FIFO is zero.
  - beat_cnt increments on each transfer only; full stalls are not counted.
- Burst end:
  - If a transfer brings beat_cnt to MAX_BURST, or req_valid[owner]=0 in any BURST cycle:
    - go to IDLE;
    - set rr_ptr = (owner+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0.
  - A cycle where the owner drops valid has no transfer.
- fifo_full=1 with valid high: stay in BURST, ready=0, wr_en=0, beat_cnt held. No timeout.
- en=0 during BURST: the current burst completes; en only blocks the IDLE->BURST transition.
- The producer must hold data stable while valid & !ready.
- With a single persistently valid producer, the grant sequence is MAX_BURST beats, 1 bubble, repeat.
- fifo_data_in = 0 whenever fifo_wr_en = 0.
- busy = (state==BURST); grant_id = owner in BURST, 0 in IDLE.
- Reset mid-burst: the partial burst is abandoned with no further writes. After release, arbitration restarts from index 0.

Decomposition:
- Package fifo_arb_pkg:
  - state_t enum {IDLE, BURST};
  - function rr_next(ptr, NUM_REQ) for the modulo increment.
- Sub-module rr_picker:
  - combinational first-set search from a rotating start pointer;
  - inputs: valid vector, rr_ptr;
  - outputs: found, idx.

Test Plan:
1. Hold rst=0 with random inputs -> every output is 0. Release, all req_valid=0 for 10 cycles -> fifo_wr_en never asserts.
2. Only producer 2 valid with 6 beats 0x10..0x15, fifo_full=0, MAX_BURST=4 -> 1 bubble; 0x10..0x13 written with fifo_src=2; 1 bubble; 0x14,0x15 written; then IDLE.
3. All 4 producers continuously valid -> grant order 0,1,2,3,0. Each grant is 4 writes followed by 1 bubble, giving a 5-cycle period. The wrap from 3 to 0 is verified.
4. Producer 1 bursting; fifo_full=1 for 3 cycles after beat 2 -> req_ready[1]=0 and wr_en=0 for those 3 cycles. Beats 3-4 follow; exactly 4 beats total, then rotate to 2.
5. Producers 0 and 3 valid; producer 0 drops valid after 1 beat -> IDLE; the next grant goes to 3; the next grant after that goes to 0.
6. Assert rst mid-burst after beat 2 of producer 2 -> outputs go to 0 immediately. After release with 1 and 3 valid, the first grant goes to 1 (search starts at rr_ptr=0).
